// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU slice: operation codes, the serial
// add/subtract FSM state encoding and the default datapath widths that the
// add/subtract stage and the right shifter agree on.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Default operand width and shift-amount width shared with the shifter.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_SHW   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_full_adder.sv
// ---------------------------------------------------------------------------
// alu_full_adder
// One-bit full adder used as the serial arithmetic element.
// Ports:
//   a, b  in   operand bits
//   cin   in   carry in
//   s     out  sum bit
//   cout  out  carry out
// ---------------------------------------------------------------------------
module alu_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/alu_serial_addsub.sv
// ---------------------------------------------------------------------------
// alu_serial_addsub
// Bit-serial add/subtract stage producing the sumrest operand for the right
// shifter. Operands are captured on an accepted start and processed one bit
// per clock, LSB first. On completion the result, flags and the forwarded
// shift amount are registered together and held until the next completion.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   request, sampled only in IDLE
//   op        in   0 = add, 1 = subtract
//   a, b      in   operands (WIDTH)
//   movr_in   in   shift amount forwarded to the shifter (SHW)
//   busy      out  high in RUN and DONE
//   done      out  one-cycle pulse when outputs update
//   sumrest   out  registered result (WIDTH)
//   carry     out  add: carry-out, sub: borrow
//   overflow  out  signed overflow
//   zero      out  sumrest == 0
//   movr      out  shift amount belonging to sumrest (SHW)
// WIDTH must be at least 3.
// ---------------------------------------------------------------------------
module alu_serial_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   movr_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sumrest,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic [SHW-1:0]   movr
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh;
    // Holds the low WIDTH-1 result bits; the MSB comes straight from the
    // adder on the final edge, so sumrest never exposes partial results.
    logic [WIDTH-2:0] acc;
    logic             cy;
    logic             op_q;
    logic [SHW-1:0]   movr_q;
    logic             fa_s, fa_cout;
    logic             load, step, last;

    alu_full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (cy),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) begin
                    last       = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            cy       <= 1'b0;
            op_q     <= 1'b0;
            movr_q   <= '0;
            done     <= 1'b0;
            sumrest  <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            movr     <= '0;
        end else begin
            done <= 1'b0;

            if (load) begin
                // Subtract is a + ~b + 1: invert B once here and seed the
                // carry with 1.
                a_sh   <= a;
                b_sh   <= b ^ {WIDTH{op}};
                op_q   <= op;
                cy     <= (op == OP_SUB);
                movr_q <= movr_in;
                cnt    <= '0;
            end

            if (step) begin
                a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                acc  <= {fa_s, acc[WIDTH-2:1]};
                cy   <= fa_cout;
                cnt  <= cnt + 1'b1;
            end

            if (last) begin
                sumrest  <= {fa_s, acc};
                // A subtract with no carry out means a borrow occurred.
                carry    <= (op_q == OP_SUB) ? ~fa_cout : fa_cout;
                // cy is the carry into the MSB during this final bit.
                overflow <= cy ^ fa_cout;
                zero     <= ({fa_s, acc} == '0);
                movr     <= movr_q;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_addsub
// Self-checking bench: reset behaviour, directed vectors from a table,
// busy/abort sequences and randomized operations against an arithmetic
// reference model.
// ---------------------------------------------------------------------------
module tb_alu_serial_addsub;

    localparam int W = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a, b;
    logic [S-1:0] movr_in;
    logic         busy, done, carry, overflow, zero;
    logic [W-1:0] sumrest;
    logic [S-1:0] movr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [S-1:0] m;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    alu_serial_addsub #(.WIDTH(W), .SHW(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .movr_in  (movr_in),
        .busy     (busy),
        .done     (done),
        .sumrest  (sumrest),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .movr     (movr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed values.
    function automatic vec_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                   input logic vop, input logic [S-1:0] vm);
        vec_t v;
        int   ua, ub, sa, sb, ur, sr;
        ua = int'(va);
        ub = int'(vb);
        sa = int'($signed(va));
        sb = int'($signed(vb));
        ur = vop ? ua - ub : ua + ub;
        sr = vop ? sa - sb : sa + sb;
        v.a  = va;
        v.b  = vb;
        v.op = vop;
        v.m  = vm;
        v.r  = ur[W-1:0];
        v.c  = vop ? (ua < ub) : (ur > 255);
        v.v  = (sr > 127) || (sr < -128);
        v.z  = (ur[W-1:0] == 0);
        return v;
    endfunction

    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vop, input logic [S-1:0] vm);
        a       = va;
        b       = vb;
        op      = vop;
        movr_in = vm;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic check_result(input string name, input vec_t v);
        check({name, " sumrest"},  32'(sumrest),  32'(v.r));
        check({name, " carry"},    32'(carry),    32'(v.c));
        check({name, " overflow"}, 32'(overflow), 32'(v.v));
        check({name, " zero"},     32'(zero),     32'(v.z));
        check({name, " movr"},     32'(movr),     32'(v.m));
    endtask

    // Full transaction: launch, latency, results, then the return to IDLE.
    task automatic run_vec(input string name, input vec_t v);
        int n;
        launch(v.a, v.b, v.op, v.m);
        check({name, " busy after start"}, 32'(busy), 32'd1);
        // Scramble inputs: only captured copies may matter.
        a       = ~v.a;
        b       = v.a;
        op      = ~v.op;
        movr_in = ~v.m;
        wait_done(n);
        check({name, " latency"}, 32'(n), 32'(W));
        check({name, " busy in done"}, 32'(busy), 32'd1);
        check_result(name, v);
        tick();
        check({name, " done pulse width"}, 32'(done), 32'd0);
        check({name, " busy after done"}, 32'(busy), 32'd0);
        check({name, " sumrest held"}, 32'(sumrest), 32'(v.r));
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;
        int   n;
        int   seen;

        tbl[0] = '{a: 8'h3C, b: 8'h05, op: 1'b0, m: 3'd2, r: 8'h41, c: 1'b0, v: 1'b0, z: 1'b0};
        tbl[1] = '{a: 8'h05, b: 8'h06, op: 1'b1, m: 3'd1, r: 8'hFF, c: 1'b1, v: 1'b0, z: 1'b0};
        tbl[2] = '{a: 8'h80, b: 8'h80, op: 1'b1, m: 3'd7, r: 8'h00, c: 1'b0, v: 1'b0, z: 1'b1};
        tbl[3] = '{a: 8'h7F, b: 8'h01, op: 1'b0, m: 3'd3, r: 8'h80, c: 1'b0, v: 1'b1, z: 1'b0};
        tbl[4] = '{a: 8'hFF, b: 8'h01, op: 1'b0, m: 3'd4, r: 8'h00, c: 1'b1, v: 1'b0, z: 1'b1};
        tbl[5] = '{a: 8'h80, b: 8'h01, op: 1'b1, m: 3'd5, r: 8'h7F, c: 1'b0, v: 1'b1, z: 1'b0};
        tbl[6] = '{a: 8'h00, b: 8'h01, op: 1'b1, m: 3'd6, r: 8'hFF, c: 1'b1, v: 1'b0, z: 1'b0};

        // Reset sweep with start asserted: start must be ignored.
        rst_n   = 1'b0;
        start   = 1'b1;
        op      = 1'b0;
        a       = 8'h3C;
        b       = 8'h05;
        movr_in = 3'd2;
        tick();
        tick();
        v = '{a: 8'h0, b: 8'h0, op: 1'b0, m: 3'd0, r: 8'h0, c: 1'b0, v: 1'b0, z: 1'b0};
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check_result("reset", v);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        check("idle after reset busy", 32'(busy), 32'd0);

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Start pulses and input changes mid-RUN are ignored.
        launch(8'h3C, 8'h05, 1'b0, 3'd2);
        a       = 8'hFF;
        b       = 8'hFF;
        op      = 1'b1;
        movr_in = 3'd7;
        start   = 1'b1;
        tick();
        tick();
        tick();
        start   = 1'b0;
        a       = 8'h00;
        wait_done(n);
        check("busy-ignore latency", 32'(n), 32'(W - 3));
        check_result("busy-ignore", tbl[0]);
        tick();

        // Abort with reset while bit 4 is pending.
        launch(8'h7F, 8'h01, 1'b0, 3'd5);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check_result("abort", v);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) seen++;
        end
        check("abort no done", 32'(seen), 32'd0);
        run_vec("after abort", tbl[0]);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            v = model(W'($urandom), W'($urandom), 1'($urandom), S'($urandom));
            run_vec($sformatf("rand%0d", i), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
